// File: rtl/sd_cmd_serial.sv
// sd_cmd_serial: bit-level SD CMD line engine.
// Serializes a 40-bit command frame with CRC7 and end bit onto the CMD pin,
// then optionally captures a 48-bit or 136-bit card response, checks its CRC7,
// end bit and index field, and hands the payload back with a one-cycle
// finish pulse after the NCC idle gap.
module sd_cmd_serial #(
  parameter int RESP_W = 120,
  parameter int NCC    = 8
) (
  input  logic              sd_clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              go_idle_i,
  input  logic [39:0]       cmd_i,
  input  logic [1:0]        setting_i,
  input  logic              cmd_dat_i,
  output logic              cmd_out_o,
  output logic              cmd_oe_o,
  output logic [RESP_W-1:0] response_o,
  output logic              crc_ok_o,
  output logic              index_ok_o,
  output logic              finish_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_RX_TURN,
    S_RX_WAIT,
    S_RX,
    S_NCC_WAIT
  } state_t;

  // Bit-counter milestones. TX count 48 is the release cycle after the end
  // bit; RX counts are measured from the start bit (count 0).
  localparam logic [7:0] TX_CMD_END  = 8'd40;
  localparam logic [7:0] TX_CRC_END  = 8'd47;
  localparam logic [7:0] TX_RELEASE  = 8'd48;
  localparam logic [7:0] RX_LAST_S   = 8'd47;
  localparam logic [7:0] RX_LAST_L   = 8'd135;
  localparam logic [7:0] NCC_LAST    = 8'(NCC - 1);

  // CRC7, polynomial x^7 + x^3 + 1, one bit per call, MSB first.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  state_t              r_state;
  state_t              w_state_next;
  logic [38:0]         r_tx_sh;     // remaining command bits, MSB next
  logic [5:0]          r_index;     // command index for the response check
  logic [1:0]          r_setting;   // {long_response, expect_response}
  logic [7:0]          r_cnt;
  logic [6:0]          r_crc;       // shared by TX generation and RX check
  logic [132:0]        r_shift;     // received bit b lands in r_shift[b-1]
  logic                r_cmd_out;
  logic                r_cmd_oe;
  logic [RESP_W-1:0]   r_response;
  logic                r_crc_ok;
  logic                r_index_ok;
  logic                r_finish;

  logic                w_long;
  logic                w_expect;
  logic                w_tx_end;
  logic                w_rx_end;
  logic                w_ncc_end;
  logic                w_rx_crc_en;

  assign w_long   = r_setting[1];
  assign w_expect = r_setting[0];

  assign w_tx_end  = (r_state == S_TX) && (r_cnt == TX_RELEASE);
  assign w_rx_end  = (r_state == S_RX) && (r_cnt == (w_long ? RX_LAST_L : RX_LAST_S));
  assign w_ncc_end = (r_state == S_NCC_WAIT) && (r_cnt == NCC_LAST);

  // The start bit is zero and the CRC starts at zero, so the start bit never
  // changes the CRC; only bits after it are folded in. A long response covers
  // bits 127..8 (counts 8..127); a short one covers 46..8 (counts 1..39).
  assign w_rx_crc_en = w_long ? ((r_cnt >= 8'd8) && (r_cnt <= 8'd127))
                              : ((r_cnt >= 8'd1) && (r_cnt <= 8'd39));

  // State register.
  always_ff @(posedge sd_clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode; abort wins over everything.
  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch
    // is inferred.
    w_state_next = r_state;
    if (go_idle_i) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (start_i)    w_state_next = S_TX;
        S_TX:       if (w_tx_end)   w_state_next = w_expect ? S_RX_TURN : S_NCC_WAIT;
        // The sample at E48 is taken during the last TX cycle, so one more
        // cycle here discards E49 and the start-bit search begins at E50.
        S_RX_TURN:                  w_state_next = S_RX_WAIT;
        S_RX_WAIT:  if (!cmd_dat_i) w_state_next = S_RX;
        S_RX:       if (w_rx_end)   w_state_next = S_NCC_WAIT;
        S_NCC_WAIT: if (w_ncc_end)  w_state_next = S_IDLE;
        default:                    w_state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: CMD pin drive, bit counter, CRC, receive shifter and status.
  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sh    <= '0;
      r_index    <= '0;
      r_setting  <= '0;
      r_cnt      <= '0;
      r_crc      <= '0;
      // NOTE: the receive shifter is cleared at every start bit, so its reset
      // is not functionally needed; it is kept for a deterministic post-reset
      // state in simulation and equivalence checks.
      r_shift    <= '0;
      r_cmd_out  <= 1'b1;
      r_cmd_oe   <= 1'b0;
      r_response <= '0;
      r_crc_ok   <= 1'b0;
      r_index_ok <= 1'b0;
      r_finish   <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      if (go_idle_i) begin
        // Release the pin and clear the counter; status is left untouched.
        r_cmd_oe  <= 1'b0;
        r_cmd_out <= 1'b1;
        r_cnt     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_tx_sh    <= cmd_i[38:0];
              r_index    <= cmd_i[37:32];
              r_setting  <= setting_i;
              r_cmd_out  <= cmd_i[39];
              r_cmd_oe   <= 1'b1;
              r_crc      <= crc7_next(7'd0, cmd_i[39]);
              r_cnt      <= 8'd1;
              r_response <= '0;
              r_crc_ok   <= 1'b0;
              r_index_ok <= 1'b0;
            end
          end

          S_TX: begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt < TX_CMD_END) begin
              r_cmd_out <= r_tx_sh[38];
              r_crc     <= crc7_next(r_crc, r_tx_sh[38]);
              r_tx_sh   <= {r_tx_sh[37:0], 1'b0};
            end else if (r_cnt < TX_CRC_END) begin
              r_cmd_out <= r_crc[6];
              r_crc     <= {r_crc[5:0], 1'b0};
            end else if (r_cnt == TX_CRC_END) begin
              r_cmd_out <= 1'b1;            // end bit
            end else begin
              r_cmd_oe  <= 1'b0;
              r_cmd_out <= 1'b1;
              // The NCC gap is measured from the end bit (E47), which was one
              // edge ago when there is no response to wait for.
              r_cnt     <= w_expect ? 8'd0 : 8'd1;
            end
          end

          S_RX_TURN: begin
            r_cnt <= '0;
          end

          S_RX_WAIT: begin
            if (!cmd_dat_i) begin
              r_cnt   <= 8'd1;
              r_crc   <= '0;
              r_shift <= '0;
            end
          end

          S_RX: begin
            if (w_rx_end) begin
              r_cnt    <= '0;
              r_crc_ok <= (r_shift[6:0] == r_crc) && cmd_dat_i;
              if (w_long) begin
                r_response <= r_shift[126 -: RESP_W];
                r_index_ok <= (r_shift[132:127] == 6'h3F);
              end else begin
                r_response <= {r_shift[38:7], {(RESP_W-32){1'b0}}};
                r_index_ok <= (r_shift[44:39] == r_index);
              end
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_shift <= {r_shift[131:0], cmd_dat_i};
              if (w_rx_crc_en) r_crc <= crc7_next(r_crc, cmd_dat_i);
            end
          end

          S_NCC_WAIT: begin
            if (w_ncc_end) begin
              r_finish <= 1'b1;
              r_cnt    <= '0;
              if (!w_expect) begin
                // Nothing to check on a no-response command: report success.
                r_crc_ok   <= 1'b1;
                r_index_ok <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end

          default: begin
            r_cmd_oe  <= 1'b0;
            r_cmd_out <= 1'b1;
            r_cnt     <= '0;
          end
        endcase
      end
    end
  end

  assign cmd_out_o  = r_cmd_out;
  assign cmd_oe_o   = r_cmd_oe;
  assign response_o = r_response;
  assign crc_ok_o   = r_crc_ok;
  assign index_ok_o = r_index_ok;
  assign finish_o   = r_finish;

endmodule

// File: tb/tb_sd_cmd_serial.sv
// Testbench for sd_cmd_serial: directed command/response vectors with
// hand-computed frames and CRCs; a frame monitor and a result monitor pop
// expectations from scoreboard queues whenever the DUT presents output.
module tb_sd_cmd_serial;

  localparam int RESP_W = 120;
  localparam int NCC    = 8;

  // R2 payload with bits 119, 38, 32 and 0 set. CRC7 over it is the XOR of
  // x^126, x^45, x^39 and x^7 mod (x^7+x^3+1) = 0x44^0x4A^0x36^0x09 = 0x31.
  localparam logic [119:0] R2_PAYLOAD = 120'h80_0000_0000_0000_0000_0041_0000_0001;

  logic              sd_clk    = 1'b0;
  logic              rst_n     = 1'b0;
  logic              start_i   = 1'b0;
  logic              go_idle_i = 1'b0;
  logic [39:0]       cmd_i     = '0;
  logic [1:0]        setting_i = '0;
  logic              cmd_dat_i = 1'b1;
  logic              cmd_out_o;
  logic              cmd_oe_o;
  logic [RESP_W-1:0] response_o;
  logic              crc_ok_o;
  logic              index_ok_o;
  logic              finish_o;

  sd_cmd_serial #(.RESP_W(RESP_W), .NCC(NCC)) dut (
    .sd_clk     (sd_clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .go_idle_i  (go_idle_i),
    .cmd_i      (cmd_i),
    .setting_i  (setting_i),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_out_o  (cmd_out_o),
    .cmd_oe_o   (cmd_oe_o),
    .response_o (response_o),
    .crc_ok_o   (crc_ok_o),
    .index_ok_o (index_ok_o),
    .finish_o   (finish_o)
  );

  always #5 sd_clk = ~sd_clk;

  // Edge counter: read at a negedge it equals the index of the edge just past.
  int unsigned n_edge = 0;
  always @(posedge sd_clk) n_edge <= n_edge + 1;

  typedef struct {
    logic [119:0] resp;
    logic         crc_ok;
    logic         idx_ok;
    int unsigned  fin_edge;
  } exp_t;

  exp_t        q_res[$];
  logic [47:0] q_frame[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Frame monitor: collects 48 driven bits and checks the pin is released next.
  initial begin : frame_mon
    logic [47:0] sh;
    int nb;
    sh = '0;
    nb = 0;
    forever begin
      @(negedge sd_clk);
      if (rst_n && cmd_oe_o) begin
        sh = {sh[46:0], cmd_out_o};
        nb++;
        if (nb == 48) begin
          if (q_frame.size() == 0) check("unexpected_frame", 1, 0);
          else check("tx_frame", sh, q_frame.pop_front());
          @(negedge sd_clk);
          check("tx_release", {cmd_oe_o, cmd_out_o}, 2'b01);
          nb = 0;
        end
      end
    end
  end

  // Result monitor: compares payload, status and timing at each finish pulse.
  initial begin : res_mon
    exp_t e;
    forever begin
      @(negedge sd_clk);
      if (rst_n && finish_o) begin
        if (q_res.size() == 0) begin
          check("unexpected_finish", 1, 0);
        end else begin
          e = q_res.pop_front();
          check("response",    response_o, e.resp);
          check("crc_ok",      crc_ok_o,   e.crc_ok);
          check("index_ok",    index_ok_o, e.idx_ok);
          check("finish_edge", n_edge,     e.fin_edge);
        end
      end
    end
  end

  // One command transaction; len==0 means no card reply is driven.
  task automatic run_cmd(input logic [39:0] cmd, input logic [1:0] setting,
                         input logic [47:0] frame_tx, input logic [135:0] reply,
                         input int len, input int s_rel, input bit pre_low,
                         input bit stray, input logic [119:0] exp_resp,
                         input bit exp_crc, input bit exp_idx);
    exp_t e;
    int unsigned e0;
    int last;
    @(negedge sd_clk);
    e0         = n_edge + 1;
    e.resp     = exp_resp;
    e.crc_ok   = exp_crc;
    e.idx_ok   = exp_idx;
    e.fin_edge = (len == 0) ? e0 + 55 : e0 + s_rel + len - 1 + NCC;
    q_frame.push_back(frame_tx);
    q_res.push_back(e);
    start_i   = 1'b1;
    cmd_i     = cmd;
    setting_i = setting;
    last      = (len == 0) ? 12 : s_rel + len - 1;
    for (int k = 1; k <= last; k++) begin
      @(negedge sd_clk);
      if (k == 1) check("clear_on_start", {response_o, crc_ok_o, index_ok_o}, '0);
      // Inputs change after acceptance to prove they were latched.
      cmd_i     = ~cmd;
      setting_i = ~setting;
      start_i   = stray && (k == 10);
      cmd_dat_i = 1'b1;
      if (pre_low && (k == 48 || k == 49)) cmd_dat_i = 1'b0;
      if (len > 0 && k >= s_rel) cmd_dat_i = reply[len - 1 - (k - s_rel)];
    end
    @(negedge sd_clk);
    cmd_dat_i = 1'b1;
    start_i   = 1'b0;
    for (int t = 0; t < 400 && q_res.size() != 0; t++) @(negedge sd_clk);
    check("drain", q_res.size(), 0);
    repeat (3) @(negedge sd_clk);
  endtask

  initial begin : stim
    logic [135:0] r2;
    r2 = {2'b00, 6'h3F, R2_PAYLOAD, 7'h31, 1'b1};

    repeat (3) @(negedge sd_clk);
    check("rst_oe_out", {cmd_oe_o, cmd_out_o}, 2'b01);
    rst_n = 1'b1;
    @(negedge sd_clk);
    check("reset_oe",       cmd_oe_o,   0);
    check("reset_out",      cmd_out_o,  1);
    check("reset_finish",   finish_o,   0);
    check("reset_status",   {crc_ok_o, index_ok_o}, 2'b00);
    check("reset_response", response_o, 0);

    // CMD0, no response; a stray start during TX must be ignored.
    run_cmd(40'h40_0000_0000, 2'b00, 48'h40_0000_0000_95, '0, 0, 0, 0, 1,
            120'd0, 1, 1);
    // CMD8 with a correct R7 reply starting at E52 (finish after E107).
    run_cmd(40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87, 136'h08_0000_01AA_13,
            48, 52, 0, 0, {32'h0000_01AA, 88'd0}, 1, 1);
    // CMD2 with a 136-bit R2 reply.
    run_cmd(40'h42_0000_0000, 2'b11, 48'h42_0000_0000_4D, r2,
            136, 55, 0, 0, R2_PAYLOAD, 1, 1);
    // R7 with the last CRC bit flipped.
    run_cmd(40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87, 136'h08_0000_01AA_11,
            48, 52, 0, 0, {32'h0000_01AA, 88'd0}, 0, 1);
    // R7 with end bit 0.
    run_cmd(40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87, 136'h08_0000_01AA_12,
            48, 52, 0, 0, {32'h0000_01AA, 88'd0}, 0, 1);
    // Reply carrying index 9 with its own valid CRC (0x09^0x36 = 0x3F).
    run_cmd(40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87, 136'h09_0000_01AA_7F,
            48, 52, 0, 0, {32'h0000_01AA, 88'd0}, 1, 0);
    // Zeros during turnaround are ignored; start bit at E50 (finish after E105).
    run_cmd(40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87, 136'h08_0000_01AA_13,
            48, 50, 1, 0, {32'h0000_01AA, 88'd0}, 1, 1);

    // Abort while waiting for a reply that never comes.
    @(negedge sd_clk);
    q_frame.push_back(48'h48_0000_01AA_87);
    start_i   = 1'b1;
    cmd_i     = 40'h48_0000_01AA;
    setting_i = 2'b01;
    for (int k = 1; k <= 60; k++) begin
      @(negedge sd_clk);
      start_i   = 1'b0;
      cmd_dat_i = 1'b1;
      go_idle_i = (k == 60);
    end
    @(negedge sd_clk);
    go_idle_i = 1'b0;
    check("abort_pin", {cmd_oe_o, cmd_out_o}, 2'b01);
    check("abort_status_kept", {crc_ok_o, index_ok_o}, 2'b00);
    repeat (150) @(negedge sd_clk);

    // A new command after the abort runs normally.
    run_cmd(40'h40_0000_0000, 2'b00, 48'h40_0000_0000_95, '0, 0, 0, 0, 0,
            120'd0, 1, 1);

    // go_idle together with start in IDLE drops the start.
    @(negedge sd_clk);
    start_i   = 1'b1;
    go_idle_i = 1'b1;
    cmd_i     = 40'h40_0000_0000;
    setting_i = 2'b00;
    @(negedge sd_clk);
    start_i   = 1'b0;
    go_idle_i = 1'b0;
    check("dropped_start_oe", cmd_oe_o, 0);
    repeat (70) @(negedge sd_clk);
    check("dropped_start_status", {crc_ok_o, index_ok_o}, 2'b11);

    check("frames_left", q_frame.size(), 0);
    check("results_left", q_res.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
